// File: rtl/alien_formation_stepper.sv
// -----------------------------------------------------------------------------
// alien_formation_stepper
//
// Movement controller for the alien formation. A self-timed period counter
// issues steps. On each step the formation moves H_STEP pixels horizontally,
// or, if the live edge of the formation would cross a playfield bound, it
// drops V_STEP rows and reverses direction. The step period is reloaded on
// every step from the number of live columns, so the cadence speeds up as
// columns are destroyed.
//
// Ports
//   Clk            rising-edge clock
//   Reset_n        synchronous active-low reset
//   Enable         period counter advances only while high
//   Restart        synchronous new-wave restart (same effect as reset)
//   AliveCols      bit i set -> column i still has a live alien
//   AliensRow      formation top row
//   AliensCol      signed x of column 0 origin (COL_W+1 bits, two's complement)
//   MovingRight    current horizontal direction
//   StepPulse      one-cycle strobe for every executed step or drop
//   Reached_Bottom sticky invasion flag; freezes motion until reset/restart
//   Cleared        combinational, no live columns remain
// -----------------------------------------------------------------------------

// Per-column edge calculator: pixel extent of column IDX given the
// formation origin. One instance per column; the top picks the extreme
// live columns out of these.
module afs_col_edge #(
    parameter int CW        = 12,
    parameter int IDX       = 0,
    parameter int COL_PITCH = 35,
    parameter int ALIEN_W   = 30
) (
    input  logic signed [CW-1:0] origin,
    output logic signed [CW-1:0] left_edge,
    output logic signed [CW-1:0] right_edge
);
    localparam logic signed [CW-1:0] OFFSET = CW'(IDX * COL_PITCH);
    localparam logic signed [CW-1:0] WIDTH  = CW'(ALIEN_W);

    assign left_edge  = origin + OFFSET;
    assign right_edge = origin + OFFSET + WIDTH;
endmodule

module alien_formation_stepper #(
    parameter int ROW_W       = 9,
    parameter int COL_W       = 10,
    parameter int NCOLS       = 11,
    parameter int COL_PITCH   = 35,
    parameter int ALIEN_W     = 30,
    parameter int FORMATION_H = 150,
    parameter int H_STEP      = 5,
    parameter int V_STEP      = 10,
    parameter int LEFT_BOUND  = 10,
    parameter int RIGHT_BOUND = 630,
    parameter int BOTTOM_ROW  = 400,
    parameter int START_ROW   = 0,
    parameter int START_COL   = 10,
    parameter int PERIOD_W    = 20,
    parameter int PERIOD_MIN  = 1,
    parameter int PERIOD_DEC  = 0
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Enable,
    input  logic             Restart,
    input  logic [NCOLS-1:0] AliveCols,
    output logic [ROW_W-1:0] AliensRow,
    output logic [COL_W:0]   AliensCol,
    output logic             MovingRight,
    output logic             StepPulse,
    output logic             Reached_Bottom,
    output logic             Cleared
);
    // Edge arithmetic is done one bit wider than the column output so the
    // column offsets can be added to a negative origin without wrapping.
    localparam int CW    = COL_W + 2;
    localparam int CNT_W = $clog2(NCOLS + 1);

    localparam logic [ROW_W-1:0]    START_ROW_V  = ROW_W'(START_ROW);
    localparam logic [COL_W:0]      START_COL_V  = (COL_W + 1)'(START_COL);
    localparam logic [COL_W:0]      H_STEP_COL   = (COL_W + 1)'(H_STEP);
    localparam logic [ROW_W-1:0]    V_STEP_ROW   = ROW_W'(V_STEP);
    localparam logic [PERIOD_W-1:0] START_PERIOD = PERIOD_W'(PERIOD_MIN + PERIOD_DEC * NCOLS);

    // Bounds folded with the step size: "R + H_STEP > RIGHT_BOUND" becomes
    // "R > RIGHT_BOUND - H_STEP", and likewise on the left, so the compare
    // never needs a further addition.
    localparam logic signed [CW-1:0] RIGHT_LIM = CW'(RIGHT_BOUND - H_STEP);
    localparam logic signed [CW-1:0] LEFT_LIM  = CW'(LEFT_BOUND + H_STEP);

    logic [PERIOD_W-1:0] count;
    logic [PERIOD_W-1:0] period;

    logic signed [CW-1:0] origin;
    logic signed [CW-1:0] lane_left  [NCOLS];
    logic signed [CW-1:0] lane_right [NCOLS];
    logic signed [CW-1:0] left_edge;
    logic signed [CW-1:0] right_edge;
    logic [CNT_W-1:0]     alive_cnt;

    logic                 count_run;
    logic                 step;
    logic                 drop;
    logic [ROW_W-1:0]     drop_row;
    logic [31:0]          drop_bottom;
    logic                 drop_reach;
    logic [COL_W:0]       move_col;
    logic [PERIOD_W-1:0]  next_period;

    assign Cleared = (AliveCols == '0);
    assign origin  = signed'({AliensCol[COL_W], AliensCol});

    genvar gi;
    generate
        for (gi = 0; gi < NCOLS; gi++) begin : g_lane
            afs_col_edge #(
                .CW        (CW),
                .IDX       (gi),
                .COL_PITCH (COL_PITCH),
                .ALIEN_W   (ALIEN_W)
            ) u_edge (
                .origin     (origin),
                .left_edge  (lane_left[gi]),
                .right_edge (lane_right[gi])
            );
        end
    endgenerate

    // Lowest live column sets the left edge, highest sets the right edge.
    // Scan directions make the last assignment win for the extreme column.
    always_comb begin
        left_edge  = '0;
        right_edge = '0;
        alive_cnt  = '0;
        for (int i = NCOLS - 1; i >= 0; i--) begin
            if (AliveCols[i]) left_edge = lane_left[i];
        end
        for (int i = 0; i < NCOLS; i++) begin
            if (AliveCols[i]) right_edge = lane_right[i];
            alive_cnt = alive_cnt + CNT_W'(AliveCols[i]);
        end
    end

    // Counter runs only while enabled and the wave is still in play.
    assign count_run = Enable && !Reached_Bottom && !Cleared;
    assign step      = count_run && (count == period - PERIOD_W'(1));

    assign drop        = MovingRight ? (right_edge > RIGHT_LIM) : (left_edge < LEFT_LIM);
    assign drop_row    = AliensRow + V_STEP_ROW;
    assign drop_bottom = 32'(drop_row) + 32'(FORMATION_H);
    assign drop_reach  = (drop_bottom >= 32'(BOTTOM_ROW));
    assign move_col    = MovingRight ? (AliensCol + H_STEP_COL) : (AliensCol - H_STEP_COL);
    assign next_period = PERIOD_W'(PERIOD_MIN + PERIOD_DEC * int'(alive_cnt));

    always_ff @(posedge Clk) begin
        if (!Reset_n || Restart) begin
            AliensRow      <= START_ROW_V;
            AliensCol      <= START_COL_V;
            MovingRight    <= 1'b1;
            StepPulse      <= 1'b0;
            Reached_Bottom <= 1'b0;
            count          <= '0;
            period         <= START_PERIOD;
        end else begin
            StepPulse <= 1'b0;
            if (count_run) begin
                if (step) begin
                    count     <= '0;
                    period    <= next_period;
                    StepPulse <= 1'b1;
                    if (drop) begin
                        AliensRow   <= drop_row;
                        MovingRight <= !MovingRight;
                        if (drop_reach) Reached_Bottom <= 1'b1;
                    end else begin
                        AliensCol <= move_col;
                    end
                end else begin
                    count <= count + PERIOD_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_alien_formation_stepper.sv
// Directed bench for alien_formation_stepper. Three instances cover the
// default cadence, a popcount-scaled period, and a shallow invasion line.
module tb_alien_formation_stepper;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: defaults
    logic        en_a = 1'b0, rs_a = 1'b0;
    logic [10:0] alive_a = 11'h7FF;
    logic [8:0]  row_a;
    logic [10:0] col_a;
    logic        mr_a, pulse_a, rb_a, clr_a;

    // Instance B: PERIOD_MIN=4, PERIOD_DEC=2
    logic        en_b = 1'b0, rs_b = 1'b0;
    logic [10:0] alive_b = 11'h7FF;
    logic [8:0]  row_b;
    logic [10:0] col_b;
    logic        mr_b, pulse_b, rb_b, clr_b;

    // Instance C: BOTTOM_ROW=170
    logic        en_c = 1'b0, rs_c = 1'b0;
    logic [10:0] alive_c = 11'h7FF;
    logic [8:0]  row_c;
    logic [10:0] col_c;
    logic        mr_c, pulse_c, rb_c, clr_c;

    alien_formation_stepper u_a (
        .Clk(clk), .Reset_n(rst_n), .Enable(en_a), .Restart(rs_a), .AliveCols(alive_a),
        .AliensRow(row_a), .AliensCol(col_a), .MovingRight(mr_a), .StepPulse(pulse_a),
        .Reached_Bottom(rb_a), .Cleared(clr_a)
    );

    alien_formation_stepper #(.PERIOD_MIN(4), .PERIOD_DEC(2)) u_b (
        .Clk(clk), .Reset_n(rst_n), .Enable(en_b), .Restart(rs_b), .AliveCols(alive_b),
        .AliensRow(row_b), .AliensCol(col_b), .MovingRight(mr_b), .StepPulse(pulse_b),
        .Reached_Bottom(rb_b), .Cleared(clr_b)
    );

    alien_formation_stepper #(.BOTTOM_ROW(170)) u_c (
        .Clk(clk), .Reset_n(rst_n), .Enable(en_c), .Restart(rs_c), .AliveCols(alive_c),
        .AliensRow(row_c), .AliensCol(col_c), .MovingRight(mr_c), .StepPulse(pulse_c),
        .Reached_Bottom(rb_c), .Cleared(clr_c)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    int pulses;

    initial begin
        // ---------------- reset state, enable high during reset
        en_a = 1'b1;
        tick(2);
        chk("rst_row", row_a, 0);
        chk("rst_col", col_a, 10);
        chk("rst_mr", mr_a, 1);
        chk("rst_pulse", pulse_a, 0);
        chk("rst_rb", rb_a, 0);
        chk("rst_clr", clr_a, 0);
        rst_n = 1'b1;

        // ---------------- A: 48 right steps, drop, 48 left steps, drop
        for (int i = 1; i <= 48; i++) begin
            tick(1);
            chk("a_right_col", col_a, 10 + 5 * i);
            chk("a_right_pulse", pulse_a, 1);
        end
        tick(1);
        chk("a_drop1_row", row_a, 10);
        chk("a_drop1_col", col_a, 250);
        chk("a_drop1_mr", mr_a, 0);
        for (int i = 1; i <= 48; i++) begin
            tick(1);
            chk("a_left_col", col_a, 250 - 5 * i);
        end
        tick(1);
        chk("a_drop2_row", row_a, 20);
        chk("a_drop2_mr", mr_a, 1);
        chk("a_drop2_col", col_a, 10);

        // ---------------- A: left columns dead, origin goes negative
        rst_n = 1'b0;
        tick(1);
        chk("a_rst2_row", row_a, 0);
        chk("a_rst2_col", col_a, 10);
        rst_n = 1'b1;
        tick(49);
        chk("a_neg_pre_row", row_a, 10);
        chk("a_neg_pre_col", col_a, 250);
        alive_a = 11'h7F8;
        tick(69);
        chk("a_neg_col", col_a, 11'h7A1);
        chk("a_neg_row", row_a, 10);
        chk("a_neg_mr", mr_a, 0);
        tick(1);
        chk("a_neg_drop_row", row_a, 20);
        chk("a_neg_drop_col", col_a, 11'h7A1);
        chk("a_neg_drop_mr", mr_a, 1);
        en_a = 1'b0;

        // ---------------- B: period 26, then 6 after one column left
        en_b = 1'b1;
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(25);
        chk("b_p1_nopulse", pulse_b, 0);
        chk("b_p1_col", col_b, 10);
        tick(1);
        chk("b_p1_pulse", pulse_b, 1);
        chk("b_p1_step", col_b, 15);
        alive_b = 11'h001;
        tick(25);
        chk("b_p2_nopulse", pulse_b, 0);
        tick(1);
        chk("b_p2_pulse", pulse_b, 1);
        chk("b_p2_step", col_b, 20);
        tick(5);
        chk("b_p3_nopulse", pulse_b, 0);
        tick(1);
        chk("b_p3_pulse", pulse_b, 1);
        chk("b_p3_step", col_b, 25);
        alive_b = 11'h000;
        #1;
        chk("b_cleared", clr_b, 1);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (pulse_b) pulses++;
        end
        chk("b_clr_pulses", pulses, 0);
        chk("b_clr_col", col_b, 25);

        // ---------------- B: enable low mid-period
        alive_b = 11'h7FF;
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(10);
        en_b = 1'b0;
        pulses = 0;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            if (pulse_b) pulses++;
        end
        chk("b_gap_pulses", pulses, 0);
        chk("b_gap_col", col_b, 10);
        en_b = 1'b1;
        tick(15);
        chk("b_resume_nopulse", pulse_b, 0);
        chk("b_resume_col", col_b, 10);
        tick(1);
        chk("b_resume_pulse", pulse_b, 1);
        chk("b_resume_step", col_b, 15);

        // ---------------- B: one-cycle reset mid-period, enabled
        tick(7);
        rst_n = 1'b0;
        tick(1);
        chk("b_mrst_row", row_b, 0);
        chk("b_mrst_col", col_b, 10);
        chk("b_mrst_mr", mr_b, 1);
        chk("b_mrst_pulse", pulse_b, 0);
        chk("b_mrst_rb", rb_b, 0);
        rst_n = 1'b1;
        tick(25);
        chk("b_mrst_nopulse", pulse_b, 0);
        tick(1);
        chk("b_mrst_pulse2", pulse_b, 1);
        chk("b_mrst_step", col_b, 15);

        // ---------------- B: one-cycle reset mid-period, disabled
        tick(5);
        en_b = 1'b0;
        rst_n = 1'b0;
        tick(1);
        chk("b_drst_col", col_b, 10);
        chk("b_drst_mr", mr_b, 1);
        rst_n = 1'b1;
        en_b = 1'b1;
        tick(25);
        chk("b_drst_nopulse", pulse_b, 0);
        tick(1);
        chk("b_drst_pulse", pulse_b, 1);
        chk("b_drst_step", col_b, 15);

        // ---------------- B: restart in a step cycle suppresses the step
        tick(25);
        rs_b = 1'b1;
        tick(1);
        rs_b = 1'b0;
        chk("b_rs_pulse", pulse_b, 0);
        chk("b_rs_col", col_b, 10);
        chk("b_rs_mr", mr_b, 1);
        tick(25);
        chk("b_rs_nopulse", pulse_b, 0);
        tick(1);
        chk("b_rs_pulse2", pulse_b, 1);
        chk("b_rs_step", col_b, 15);
        en_b = 1'b0;

        // ---------------- C: invasion line
        en_c = 1'b1;
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(49);
        chk("c_drop1_row", row_c, 10);
        chk("c_drop1_rb", rb_c, 0);
        chk("c_drop1_col", col_c, 250);
        tick(49);
        chk("c_drop2_row", row_c, 20);
        chk("c_drop2_rb", rb_c, 1);
        chk("c_drop2_col", col_c, 10);
        chk("c_drop2_mr", mr_c, 1);
        pulses = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (pulse_c) pulses++;
        end
        chk("c_frozen_pulses", pulses, 0);
        chk("c_frozen_row", row_c, 20);
        chk("c_frozen_col", col_c, 10);
        chk("c_frozen_rb", rb_c, 1);
        rs_c = 1'b1;
        tick(1);
        rs_c = 1'b0;
        chk("c_rs_row", row_c, 0);
        chk("c_rs_col", col_c, 10);
        chk("c_rs_mr", mr_c, 1);
        chk("c_rs_rb", rb_c, 0);
        tick(1);
        chk("c_rs_resume_col", col_c, 15);
        chk("c_rs_resume_pulse", pulse_c, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
